// File: rtl/if_fetch.sv
// Instruction fetch: single-outstanding ibus master feeding a small instruction FIFO.
// Define IF_PERF_CNT_EN to add fetch_cnt_o / stall_cnt_o performance counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     last_pc;
  logic            discard;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_after;
  logic            empty, push, pop;

  assign empty       = (count == '0);
  assign head        = mem[rd_ptr];
  assign push        = (state == WAIT) && ibus_rvalid_i && !discard && !jump_en_i;
  assign pop         = !empty && !hold_i && !jump_en_i;
  assign count_after = count + CW'(push) - CW'(pop);

  assign ibus_req_o    = (state == REQ);
  assign ibus_addr_o   = fetch_pc;
  assign instr_valid_o = !empty;
  assign instr_o       = empty ? NOP_INSTR : head.instr;
  assign pc_o          = empty ? last_pc : head.pc;

  // fetch_pc already advanced at grant, so the returning word belongs to fetch_pc-4
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: ibus_rdata_i, pc: fetch_pc - 32'd4};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      last_pc  <= '0;
      discard  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (jump_en_i) begin
      fetch_pc <= jump_addr_i & ~32'h3;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      case (state)
        IDLE: state <= REQ;
        REQ: if (ibus_gnt_i) begin
          state   <= WAIT;
          discard <= 1'b1;
        end
        WAIT: if (ibus_rvalid_i) begin
          // response coincides with the jump: drop it here, nothing left in flight
          state   <= REQ;
          discard <= 1'b0;
        end else begin
          discard <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end else begin
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        last_pc <= head.pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count <= count_after;
      case (state)
        IDLE: if (count < CW'(FIFO_DEPTH)) state <= REQ;
        REQ: if (ibus_gnt_i) begin
          state    <= WAIT;
          fetch_pc <= fetch_pc + 32'd4;
        end
        WAIT: if (ibus_rvalid_i) begin
          discard <= 1'b0;
          state   <= (count_after < CW'(FIFO_DEPTH)) ? REQ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (push && fetch_cnt_o != 32'hFFFF_FFFF) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (empty && !hold_i && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: bus responder plus a sequential-PC stream model, jump vector table, random soak.
module tb_if_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_i(hold_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: expected next grant address, expected next consumed pc
  logic [31:0] exp_addr, exp_pc, last_pc, pend_addr, seen_addr;
  bit          out_pend, granted, seen_req, seen_valid;
  int          pend_dly, fix_dly, gnt_pct, pops;

  typedef struct {
    logic [31:0] jaddr;
    bit          in_req;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc1;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired, got no event want event", name);
  endtask

  task automatic tick(input bit h, input bit j, input logic [31:0] ja);
    bit busy;
    @(negedge clk);
    seen_req   = ibus_req_o;
    seen_addr  = ibus_addr_o;
    seen_valid = instr_valid_o;
    busy       = out_pend;
    if (busy) chk("one_outstanding", 32'(ibus_req_o), 32'd0);
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'hDEAD_BEEF;
    if (busy) begin
      if (pend_dly == 0) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = pend_addr ^ KEY;
        out_pend      = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    ibus_gnt_i = 1'b0;
    granted    = 1'b0;
    if (ibus_req_o && !busy && (int'($urandom_range(99)) < gnt_pct)) begin
      ibus_gnt_i = 1'b1;
      granted    = 1'b1;
      chk("gnt_addr", ibus_addr_o, exp_addr);
      out_pend  = 1'b1;
      pend_addr = ibus_addr_o;
      pend_dly  = (fix_dly >= 0) ? fix_dly : int'($urandom_range(3));
      exp_addr  = exp_addr + 32'd4;
    end
    if (!instr_valid_o) begin
      chk("empty_nop", instr_o, NOP);
      chk("empty_pc", pc_o, last_pc);
    end else if (!h && !j) begin
      chk("pop_pc", pc_o, exp_pc);
      chk("pop_instr", instr_o, exp_pc ^ KEY);
      last_pc = exp_pc;
      exp_pc  = exp_pc + 32'd4;
      pops++;
    end
    if (j) begin
      exp_addr = ja & ~32'h3;
      exp_pc   = ja & ~32'h3;
    end
    hold_i      = h;
    jump_en_i   = j;
    jump_addr_i = ja;
  endtask

  task automatic do_reset(input bit late_rsp);
    @(negedge clk);
    rst_n = 1'b0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; hold_i = 1'b0; jump_en_i = 1'b0;
    out_pend = 1'b0; exp_addr = '0; exp_pc = '0; last_pc = '0;
    #1;
    chk("rst_req", 32'(ibus_req_o), 32'd0);
    chk("rst_addr", ibus_addr_o, 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    if (late_rsp) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = 32'h1234_5678;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick(1'b1, 1'b0, '0);
      ok = seen_valid;
    end
    if (!ok) timeout("wait_valid");
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick(1'b0, 1'b0, '0);
      ok = granted;
    end
    if (!ok) timeout("wait_grant");
  endtask

  initial begin
    bit ok;
    int p0;
    vec[0] = '{32'h0000_0103, 1'b0, 32'h0000_0100, 32'h0000_0104};
    vec[1] = '{32'h0000_0202, 1'b1, 32'h0000_0200, 32'h0000_0204};
    vec[2] = '{32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
    vec[3] = '{32'h0000_1001, 1'b1, 32'h0000_1000, 32'h0000_1004};
    gnt_pct = 100; fix_dly = 0; pops = 0; out_pend = 1'b0; pend_dly = 0;

    // straight-line fetch: first valid on the third cycle after release
    do_reset(1'b0);
    tick(1'b0, 1'b0, '0);
    chk("c1_valid", 32'(seen_valid), 32'd0);
    chk("c1_req", 32'(seen_req), 32'd1);
    tick(1'b0, 1'b0, '0);
    chk("c2_valid", 32'(seen_valid), 32'd0);
    tick(1'b0, 1'b0, '0);
    chk("c3_valid", 32'(seen_valid), 32'd1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, '0);

    // long hold: FIFO fills, bus parks, stream resumes without gap
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, '0);
    chk("hold_req_parked", 32'(seen_req), 32'd0);
    chk("hold_valid", 32'(seen_valid), 32'd1);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, '0);

    // jump vectors: in WAIT (stale response) or in REQ with gnt held low
    foreach (vec[k]) begin
      if (vec[k].in_req) begin
        gnt_pct = 0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
          tick(1'b0, 1'b0, '0);
          ok = seen_req;
        end
        if (!ok) timeout("wait_req");
        tick(1'b0, 1'b1, vec[k].jaddr);
        tick(1'b0, 1'b0, '0);
        chk("jreq_addr", seen_addr, vec[k].exp_pc0);
        chk("jreq_req", 32'(seen_req), 32'd1);
        tick(1'b0, 1'b0, '0);
        gnt_pct = 100;
      end else begin
        gnt_pct = 100;
        fix_dly = 2;
        wait_grant(ok);
        tick(1'b0, 1'b1, vec[k].jaddr);
        fix_dly = 0;
      end
      wait_valid(ok);
      if (ok) begin
        chk("vec_pc0", pc_o, vec[k].exp_pc0);
        chk("vec_instr0", instr_o, vec[k].exp_pc0 ^ KEY);
      end
      tick(1'b0, 1'b0, '0);
      wait_valid(ok);
      if (ok) chk("vec_pc1", pc_o, vec[k].exp_pc1);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0);
    end

    // reset while a response is outstanding, late rvalid after release
    fix_dly = 2;
    wait_grant(ok);
    do_reset(1'b1);
    fix_dly = 0;
    tick(1'b0, 1'b0, '0);
    chk("late_rsp_dropped", 32'(seen_valid), 32'd0);
    chk("restart_req", 32'(seen_req), 32'd1);
    chk("restart_addr", seen_addr, 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);

    // random soak against the stream model
    gnt_pct = 70;
    fix_dly = -1;
    p0 = pops;
    for (int i = 0; i < 3000; i++)
      tick(int'($urandom_range(99)) < 30, int'($urandom_range(99)) < 3, $urandom);
    chk("rand_progress", 32'((pops - p0) > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage. Sits directly upstream of the IF/ID pipeline register and drives its instr/pc inputs.
- Generates the PC and fetches words over a single-outstanding instruction bus (req/gnt/rvalid).
- Buffers returned words in a small FIFO so downstream hold does not stall the bus.
- Handles jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset release.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).
- NOP_INSTR, 32'h0000_0013, value driven on instr_o when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- jump_en_i  in  1  redirect request from EX
- jump_addr_i  in  32  redirect target
- hold_i  in  1  downstream stall; entry at FIFO head not consumed
- ibus_req_o  out  1  fetch request
- ibus_addr_o  out  32  fetch address, word aligned
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  response data valid
- ibus_rdata_i  in  32  response instruction word
- instr_o  out  32  instruction to IF/ID
- pc_o  out  32  PC of instr_o
- instr_valid_o  out  1  instr_o/pc_o hold a real fetched instruction

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - fetch PC = RESET_PC; FIFO empty; FSM = IDLE; discard flag = 0.
  - ibus_req_o = 0, ibus_addr_o = RESET_PC.
  - instr_o = NOP_INSTR, pc_o = 0, instr_valid_o = 0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when there is space: fifo_count < FIFO_DEPTH, with the outstanding slot counted.
  - REQ: ibus_req_o = 1, ibus_addr_o = fetch PC. On ibus_gnt_i: go to WAIT and set fetch PC = fetch PC + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - WAIT: ibus_req_o = 0. On ibus_rvalid_i: push {rdata, pc} into the FIFO unless the discard flag is set. Then go to REQ if space remains, otherwise IDLE.
- Outstanding requests: at most one. rvalid arrives ≥1 cycle after gnt.
- Bus address rule: ibus_addr_o may change only while the request is ungranted; the bus permits this.
- First request is asserted in the first cycle after reset deassertion.
- Output side:
  - instr_o/pc_o show the FIFO head combinationally; instr_valid_o = FIFO non-empty.
  - Pop when instr_valid_o && !hold_i && !jump_en_i.
  - When empty: instr_o = NOP_INSTR, pc_o = last popped pc, instr_valid_o = 0.
- Jump (priority over hold and over push/pop):
  - Fetch PC = {jump_addr_i[31:2], 2'b00}; FIFO flushed the same cycle.
  - If the FSM is in WAIT, or in REQ with gnt in the same cycle: set the discard flag. The next rvalid is dropped and clears the flag. The FSM then goes to REQ at the target.
  - If the FSM is in REQ without gnt: the request stays asserted, and ibus_addr_o shows the target from the next cycle.
  - A jump in the same cycle as an rvalid: the response is dropped; no discard flag is set.
- Simultaneous push and pop with a full FIFO: both take effect and the count is unchanged. This case cannot arise with the space rule, but the FIFO must handle it.
- hold_i held indefinitely: the FIFO fills and the FSM parks in IDLE. No data is lost.
- Reset mid-operation: all state returns to reset values. A bus response that arrives after reset is ignored, since the FSM is not in WAIT.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds two outputs, cleared on reset:
  - fetch_cnt_o (32): count of FIFO pushes.
  - stall_cnt_o (32): count of cycles with instr_valid_o=0 and hold_i=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Not defined: no counter ports and no counter logic.

Test Plan:
- Reset release with gnt tied 1 and rvalid 1 cycle after gnt, rdata = addr^32'hA5A5_0000 -> addresses 0,4,8... are issued. instr_o/pc_o stream {32'hA5A5_0000,0},{32'hA5A5_0004,4}; first instr_valid_o rises on cycle 3.
- hold_i=1 for 10 cycles mid-stream -> FIFO fills to 2 and ibus_req_o drops. After release, pc_o continues sequentially with no gap or duplicate.
- jump_en_i with jump_addr_i=32'h0000_0103 while in WAIT -> the stale response for the old PC is dropped, the next ibus_addr_o = 32'h0000_0100, and the first valid pc_o = 32'h100.
- jump_en_i while in REQ with gnt held 0 for 3 cycles -> ibus_addr_o switches to the target the next cycle and no response is discarded.
- Fetch PC at 32'hFFFF_FFFC -> the next address wraps to 32'h0000_0000.
- Assert rst_n=0 while in WAIT, then drive rvalid -> outputs return to reset values, the late rvalid is not pushed, and fetch restarts at RESET_PC.
